// File: rtl/ewb_mem_responder.sv
// Memory-side responder: arbitrates EWB line writes against L2 line reads onto one pmem port.
// Returns a one-cycle ack to the EWB and a one-cycle response (with data) to L2.
module ewb_mem_responder #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ewb_req,
  input  logic [11:0]  ewb_addr,
  input  logic [127:0] ewb_wdata,
  output logic         ewb_ack,
  input  logic         l2_read_req,
  input  logic [11:0]  l2_addr,
  output logic [127:0] l2_rdata,
  output logic         l2_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_addr,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [2:0]   dbg_state,
  output logic [3:0]   dbg_streak
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DONE  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t         r_state;
  logic [3:0]     r_streak;
  logic           r_pmem_read;
  logic           r_pmem_write;
  logic [15:0]    r_pmem_addr;
  logic [127:0]   r_pmem_wdata;
  logic [127:0]   r_l2_rdata;
  logic           r_ewb_ack;
  logic           r_l2_resp;
  logic           w_grant_wr;
  logic           w_grant_rd;

  // A write wins when it is alone, when it targets the line L2 wants (read-after-evict),
  // or when reads have been granted STARVE_LIMIT times in a row over it.
  always_comb begin
    w_grant_wr = ewb_req & (~l2_read_req | (ewb_addr == l2_addr) | (r_streak == LIMIT));
    w_grant_rd = l2_read_req & ~w_grant_wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_streak     <= 4'd0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_pmem_addr  <= 16'd0;
      r_pmem_wdata <= 128'd0;
      r_l2_rdata   <= 128'd0;
      r_ewb_ack    <= 1'b0;
      r_l2_resp    <= 1'b0;
    end else begin
      r_ewb_ack <= 1'b0;
      r_l2_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            r_state      <= WR_ISSUE;
            r_pmem_write <= 1'b1;
            r_pmem_addr  <= {ewb_addr, 4'b0000};
            r_pmem_wdata <= ewb_wdata;
            r_streak     <= 4'd0;
          end else if (w_grant_rd) begin
            r_state     <= RD_ISSUE;
            r_pmem_read <= 1'b1;
            r_pmem_addr <= {l2_addr, 4'b0000};
            if (!ewb_req) begin
              r_streak <= 4'd0;
            end else if (r_streak < LIMIT) begin
              r_streak <= 4'(r_streak + 4'd1);
            end
          end
        end
        RD_ISSUE: begin
          if (pmem_resp) begin
            r_state     <= RD_DONE;
            r_pmem_read <= 1'b0;
            r_l2_rdata  <= pmem_rdata;
            r_l2_resp   <= 1'b1;
          end
        end
        WR_ISSUE: begin
          if (pmem_resp) begin
            r_state      <= WR_DONE;
            r_pmem_write <= 1'b0;
            r_ewb_ack    <= 1'b1;
          end
        end
        RD_DONE:  r_state <= IDLE;
        WR_DONE:  r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign pmem_read  = r_pmem_read;
  assign pmem_write = r_pmem_write;
  assign pmem_addr  = r_pmem_addr;
  assign pmem_wdata = r_pmem_wdata;
  assign l2_rdata   = r_l2_rdata;
  assign l2_resp    = r_l2_resp;
  assign ewb_ack    = r_ewb_ack;
  assign dbg_state  = r_state;
  assign dbg_streak = r_streak;

endmodule

// File: tb/tb_ewb_mem_responder.sv
// Bench for ewb_mem_responder: grant table, directed corner sequences, then random traffic
// checked against a transaction-level model of the arbiter and a line-addressed memory.
module tb_ewb_mem_responder;

  localparam int LIMIT = 4;

  logic         clk;
  logic         reset_n;
  logic         ewb_req;
  logic [11:0]  ewb_addr;
  logic [127:0] ewb_wdata;
  logic         ewb_ack;
  logic         l2_read_req;
  logic [11:0]  l2_addr;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_addr;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [2:0]   dbg_state;
  logic [3:0]   dbg_streak;

  int total;
  int bad;

  ewb_mem_responder #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .ewb_req(ewb_req), .ewb_addr(ewb_addr), .ewb_wdata(ewb_wdata), .ewb_ack(ewb_ack),
    .l2_read_req(l2_read_req), .l2_addr(l2_addr), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        e_req;
    logic        l_req;
    logic [11:0] e_addr;
    logic [11:0] l_addr;
    logic        exp_wr;
    logic        exp_rd;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        ok = 1'b1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL cmd_timeout actual=none required=pmem command");
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // random-phase model state
  logic [127:0] mem [int];
  bit           ewb_pend, l2_pend, busy, release_nx, cmd_out, cur_wr, rd_valid;
  bit           grant_due, new_cmd, exp_wr, drop_e, drop_l;
  bit           exp_ack_next, exp_resp_next, exp_ack_now, exp_resp_now;
  logic [11:0]  cur_line;
  logic [127:0] exp_rdata;
  int           streak_m, lat, stall;

  initial begin
    bit ok;
    int rd_cnt;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    ewb_req = 0; ewb_addr = '0; ewb_wdata = '0;
    l2_read_req = 0; l2_addr = '0;
    pmem_rdata = '0; pmem_resp = 0;

    tbl[0] = '{1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 12'h3FF, 12'h000, 1'b1, 1'b0, 16'h3FF0};
    tbl[2] = '{1'b0, 1'b1, 12'h000, 12'h0A5, 1'b0, 1'b1, 16'h0A50};
    tbl[3] = '{1'b1, 1'b1, 12'h010, 12'h010, 1'b1, 1'b0, 16'h0100};
    tbl[4] = '{1'b1, 1'b1, 12'h020, 12'h030, 1'b0, 1'b1, 16'h0300};
    tbl[5] = '{1'b0, 1'b1, 12'h000, 12'h040, 1'b0, 1'b1, 16'h0400};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_read", pmem_read, 0);
    chk("rst_write", pmem_write, 0);
    chk("rst_ack", ewb_ack, 0);
    chk("rst_resp", l2_resp, 0);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_rdata", l2_rdata, 0);
    chk("rst_state", dbg_state, 0);

    // reset during an outstanding read
    l2_addr = 12'h055;
    l2_read_req = 1'b1;
    wait_cmd(ok);
    chk("mid_rd_issued", pmem_read, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rd_async_drop", pmem_read, 0);
    chk("mid_rd_no_resp", l2_resp, 0);
    l2_read_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_read", pmem_read, 0);
    chk("post_rst_write", pmem_write, 0);
    chk("post_rst_resp", l2_resp, 0);
    chk("post_rst_ack", ewb_ack, 0);
    chk("post_rst_addr", pmem_addr, 0);
    chk("post_rst_rdata", l2_rdata, 0);

    // grant table: one transaction per record from IDLE
    for (int v = 0; v < 6; v++) begin
      ewb_req = tbl[v].e_req; ewb_addr = tbl[v].e_addr;
      ewb_wdata = {4{20'h0, tbl[v].e_addr}};
      l2_read_req = tbl[v].l_req; l2_addr = tbl[v].l_addr;
      @(negedge clk);
      chk($sformatf("tbl%0d_wr", v), pmem_write, tbl[v].exp_wr);
      chk($sformatf("tbl%0d_rd", v), pmem_read, tbl[v].exp_rd);
      if (tbl[v].exp_wr || tbl[v].exp_rd) begin
        chk($sformatf("tbl%0d_addr", v), pmem_addr, tbl[v].exp_addr);
        if (tbl[v].exp_wr) chk($sformatf("tbl%0d_wdata", v), pmem_wdata, ewb_wdata);
        pmem_resp = 1'b1;
        pmem_rdata = rand128();
        @(negedge clk);
        pmem_resp = 1'b0;
        chk($sformatf("tbl%0d_ack", v), ewb_ack, tbl[v].exp_wr);
        chk($sformatf("tbl%0d_resp", v), l2_resp, tbl[v].exp_rd);
      end
      ewb_req = 1'b0;
      l2_read_req = 1'b0;
      @(negedge clk);
    end

    // single read with 3-cycle pmem latency; l2_addr changes while outstanding
    l2_addr = 12'h0A5;
    l2_read_req = 1'b1;
    wait_cmd(ok);
    chk("rd_addr", pmem_addr, 16'h0A50);
    l2_addr = 12'h777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_addr_stable", pmem_addr, 16'h0A50);
      chk("rd_held", pmem_read, 1);
      chk("rd_no_early_resp", l2_resp, 0);
    end
    pmem_resp = 1'b1;
    pmem_rdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = rand128();
    chk("rd_resp", l2_resp, 1);
    chk("rd_data", l2_rdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF);
    chk("rd_cmd_drop", pmem_read, 0);
    l2_read_req = 1'b0;
    @(negedge clk);
    chk("rd_resp_pulse", l2_resp, 0);
    chk("rd_data_held", l2_rdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF);

    // single write, immediate pmem_resp
    ewb_addr = 12'h3FF;
    ewb_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    ewb_req = 1'b1;
    wait_cmd(ok);
    chk("wr_cmd", pmem_write, 1);
    chk("wr_no_read", pmem_read, 0);
    chk("wr_addr", pmem_addr, 16'h3FF0);
    chk("wr_wdata", pmem_wdata, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("wr_ack", ewb_ack, 1);
    chk("wr_cmd_drop", pmem_write, 0);
    chk("wr_no_read2", pmem_read, 0);
    ewb_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", ewb_ack, 0);

    // same-line conflict: write first, one IDLE cycle, then the read
    ewb_addr = 12'h010; ewb_wdata = rand128(); ewb_req = 1'b1;
    l2_addr = 12'h010; l2_read_req = 1'b1;
    @(negedge clk);
    chk("cf_write_first", pmem_write, 1);
    chk("cf_no_read", pmem_read, 0);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("cf_ack", ewb_ack, 1);
    ewb_req = 1'b0;
    @(negedge clk);
    chk("cf_idle_gap_rd", pmem_read, 0);
    chk("cf_idle_gap_wr", pmem_write, 0);
    @(negedge clk);
    chk("cf_read_next", pmem_read, 1);
    chk("cf_read_addr", pmem_addr, 16'h0100);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("cf_resp", l2_resp, 1);
    l2_read_req = 1'b0;
    @(negedge clk);

    // starvation: four read grants over a held write, then the write, then reads resume
    ewb_addr = 12'h001; ewb_wdata = rand128(); ewb_req = 1'b1;
    l2_addr = 12'h100; l2_read_req = 1'b1;
    rd_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      wait_cmd(ok);
      if (!ok) break;
      chk($sformatf("sv%0d_wr", n), pmem_write, n == LIMIT);
      chk($sformatf("sv%0d_rd", n), pmem_read, n != LIMIT);
      if (n == LIMIT) begin
        chk("sv_wr_addr", pmem_addr, 16'h0010);
        chk("sv_streak_clr", dbg_streak, 0);
      end else begin
        chk($sformatf("sv%0d_addr", n), pmem_addr, {12'h100 + 12'(rd_cnt), 4'b0000});
        chk($sformatf("sv%0d_streak", n), dbg_streak, (n < LIMIT) ? n + 1 : 0);
        rd_cnt++;
      end
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      if (n == LIMIT) begin
        chk("sv_ack", ewb_ack, 1);
        ewb_req = 1'b0;
        @(negedge clk);
      end else begin
        chk($sformatf("sv%0d_resp", n), l2_resp, 1);
        l2_read_req = 1'b0;
        @(negedge clk);
        if (n < 5) begin
          l2_addr = 12'h100 + 12'(rd_cnt);
          l2_read_req = 1'b1;
        end
      end
    end
    ewb_req = 1'b0;
    l2_read_req = 1'b0;
    repeat (2) @(negedge clk);

    // random traffic against the transaction-level model
    ewb_pend = 0; l2_pend = 0; busy = 0; release_nx = 0; cmd_out = 0; rd_valid = 0;
    grant_due = 0; exp_ack_next = 0; exp_resp_next = 0; streak_m = 0; stall = 0;
    cur_wr = 0; cur_line = '0; lat = 0; exp_rdata = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit stop_req;
      stop_req = (cyc >= 3900);
      @(negedge clk);
      pmem_resp = 1'b0;
      exp_ack_now = exp_ack_next;
      exp_resp_now = exp_resp_next;
      exp_ack_next = 0;
      exp_resp_next = 0;
      chk("r_ack", ewb_ack, exp_ack_now);
      chk("r_resp", l2_resp, exp_resp_now);
      if (exp_resp_now) rd_valid = 1;
      if (rd_valid) chk("r_rdata", l2_rdata, exp_rdata);
      chk("r_exclusive", pmem_read & pmem_write, 0);
      if (exp_ack_now || exp_resp_now) chk("r_cmd_drop", pmem_read | pmem_write, 0);
      if (cmd_out) begin
        chk("r_cmd_hold", {pmem_write, pmem_read, pmem_addr}, {cur_wr, !cur_wr, cur_line, 4'b0000});
        if (cur_wr) chk("r_wdata_hold", pmem_wdata, ewb_wdata);
      end

      new_cmd = (pmem_read || pmem_write) && !cmd_out;
      chk("r_grant_timing", new_cmd, grant_due);
      if (new_cmd && grant_due) begin
        exp_wr = ewb_pend && (!l2_pend || ewb_addr == l2_addr || streak_m == LIMIT);
        cur_wr = exp_wr;
        cur_line = exp_wr ? ewb_addr : l2_addr;
        chk("r_grant_wr", pmem_write, exp_wr);
        chk("r_grant_rd", pmem_read, !exp_wr);
        chk("r_grant_addr", pmem_addr, {cur_line, 4'b0000});
        if (exp_wr) begin
          chk("r_grant_wdata", pmem_wdata, ewb_wdata);
          streak_m = 0;
        end else begin
          streak_m = ewb_pend ? ((streak_m < LIMIT) ? streak_m + 1 : LIMIT) : 0;
        end
        busy = 1; cmd_out = 1; stall = 0;
        lat = $urandom_range(0, 3);
      end

      drop_e = 0; drop_l = 0;
      if (release_nx) begin busy = 0; release_nx = 0; end
      if (exp_ack_now) begin ewb_req = 0; ewb_pend = 0; drop_e = 1; release_nx = 1; end
      if (exp_resp_now) begin l2_read_req = 0; l2_pend = 0; drop_l = 1; release_nx = 1; end

      if (cmd_out) begin
        if (lat == 0) begin
          pmem_resp = 1'b1;
          if (cur_wr) begin
            mem[int'(cur_line)] = ewb_wdata;
            exp_ack_next = 1;
          end else begin
            if (!mem.exists(int'(cur_line))) mem[int'(cur_line)] = rand128();
            pmem_rdata = mem[int'(cur_line)];
            exp_rdata = mem[int'(cur_line)];
            exp_resp_next = 1;
          end
          cmd_out = 0;
        end else begin
          lat--;
          pmem_rdata = rand128();
        end
      end else begin
        pmem_rdata = rand128();
        if ($urandom_range(0, 7) == 0) pmem_resp = 1'b1;
      end

      if (!stop_req && !ewb_pend && !drop_e && $urandom_range(0, 3) == 0) begin
        ewb_pend = 1; ewb_req = 1;
        ewb_addr = 12'($urandom_range(0, 7));
        ewb_wdata = rand128();
      end
      if (!l2_pend) l2_addr = 12'($urandom_range(0, 4095));
      if (!stop_req && !l2_pend && !drop_l && $urandom_range(0, 3) != 0) begin
        l2_pend = 1; l2_read_req = 1;
        l2_addr = 12'($urandom_range(0, 7));
      end

      grant_due = !busy && (ewb_pend || l2_pend);
      if (ewb_pend || l2_pend) stall++;
      if (stall > 60) begin
        total++;
        bad++;
        $display("FAIL r_stall actual=no progress required=grant within 60 cycles");
        break;
      end
    end
    ewb_req = 0;
    l2_read_req = 0;
    pmem_resp = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
